// File: rtl/rtc_alarm_timer_if.sv
// Peripheral bus bundle for rtc_alarm_timer: tick strobe, register
// access strobes/address/data and the level interrupt.
interface rtc_alarm_timer_if;
   logic        tick;
   logic        wr_en;
   logic        rd_en;
   logic [2:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        irq;

   modport master (
      output tick, wr_en, rd_en, addr, wr_data,
      input  rd_data, irq
   );

   modport slave (
      input  tick, wr_en, rd_en, addr, wr_data,
      output rd_data, irq
   );
endinterface

// File: rtl/rtc_alarm_timer.sv
// Real-time counter: seconds + sub-second counters advanced by an external
// tick, coherent sub-second snapshot and ALARM_N sticky second-match alarms.
module rtc_alarm_timer #(
   parameter int SEC_W         = 32,
   parameter int TICKS_PER_SEC = 1000000,
   parameter int SUB_W         = 20,
   parameter int ALARM_N       = 2
) (
   input logic            clk,
   input logic            rst_n,
   rtc_alarm_timer_if.slave bus
);

   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);

   logic [SEC_W-1:0]   sec_q, sec_d;
   logic [SUB_W-1:0]   sub_q, sub_d;
   logic [SUB_W-1:0]   snap_q, snap_d;
   logic               run_q, run_d;
   logic [ALARM_N-1:0] alarm_en_q, alarm_en_d;
   logic [ALARM_N-1:0] pending_q, pending_d;
   logic [SEC_W-1:0]   alarm_q [ALARM_N];
   logic [SEC_W-1:0]   alarm_d [ALARM_N];

   logic               sec_load;
   logic [ALARM_N-1:0] w1c;
   logic [ALARM_N-1:0] fire;
   logic [31:0]        rd_data_c;
   logic               unused_wr_bits;

   assign unused_wr_bits = ^bus.wr_data;

   always_comb begin
      sec_d      = sec_q;
      sub_d      = sub_q;
      snap_d     = snap_q;
      run_d      = run_q;
      alarm_en_d = alarm_en_q;
      alarm_d    = alarm_q;
      sec_load   = 1'b0;
      w1c        = '0;
      fire       = '0;

      // Snapshot takes the pre-tick sub so it matches the seconds value read now.
      if (bus.rd_en && bus.addr == 3'd0) begin
         snap_d = sub_q;
      end

      // A SECONDS write wins over a same-edge tick; that tick is dropped.
      if (bus.wr_en && bus.addr == 3'd0) begin
         sec_d    = bus.wr_data[SEC_W-1:0];
         sub_d    = '0;
         sec_load = 1'b1;
      end else if (run_q && bus.tick) begin
         if (sub_q == SUB_LAST) begin
            sub_d    = '0;
            sec_d    = sec_q + SEC_W'(1);
            sec_load = 1'b1;
         end else begin
            sub_d = sub_q + SUB_W'(1);
         end
      end

      if (bus.wr_en && bus.addr == 3'd2) begin
         run_d      = bus.wr_data[0];
         alarm_en_d = bus.wr_data[8 +: ALARM_N];
      end
      if (bus.wr_en && bus.addr == 3'd3) begin
         w1c = bus.wr_data[ALARM_N-1:0];
      end

      // Alarms fire only when sec is loaded with a new value, never on a compare write.
      for (int ch = 0; ch < ALARM_N; ch++) begin
         if (bus.wr_en && bus.addr == 3'(4 + ch)) begin
            alarm_d[ch] = bus.wr_data[SEC_W-1:0];
         end
         fire[ch] = sec_load && alarm_en_q[ch] && (sec_d == alarm_q[ch]);
      end

      pending_d = (pending_q & ~w1c) | fire;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sec_q      <= '0;
         sub_q      <= '0;
         snap_q     <= '0;
         run_q      <= 1'b1;
         alarm_en_q <= '0;
         pending_q  <= '0;
         for (int ch = 0; ch < ALARM_N; ch++) begin
            alarm_q[ch] <= '0;
         end
      end else begin
         sec_q      <= sec_d;
         sub_q      <= sub_d;
         snap_q     <= snap_d;
         run_q      <= run_d;
         alarm_en_q <= alarm_en_d;
         pending_q  <= pending_d;
         alarm_q    <= alarm_d;
      end
   end

   always_comb begin
      rd_data_c = '0;
      case (bus.addr)
         3'd0: rd_data_c[SEC_W-1:0] = sec_q;
         3'd1: rd_data_c[SUB_W-1:0] = snap_q;
         3'd2: begin
            rd_data_c[0]            = run_q;
            rd_data_c[8 +: ALARM_N] = alarm_en_q;
         end
         3'd3: rd_data_c[ALARM_N-1:0] = pending_q;
         default: begin
            for (int ch = 0; ch < ALARM_N; ch++) begin
               if (bus.addr == 3'(4 + ch)) begin
                  rd_data_c[SEC_W-1:0] = alarm_q[ch];
               end
            end
         end
      endcase
   end

   assign bus.rd_data = rd_data_c;
   assign bus.irq     = |(pending_q & alarm_en_q);

endmodule

// File: tb/tb_rtc_alarm_timer.sv
// Self-checking bench for rtc_alarm_timer with TICKS_PER_SEC=10, SEC_W=8:
// a register-access vector table followed by directed multi-cycle sequences.
`timescale 1ns/1ps
module tb_rtc_alarm_timer;

   logic clk;
   logic rst_n;
   int   nChecks;
   int   nFails;

   rtc_alarm_timer_if bus();

   rtc_alarm_timer #(
      .SEC_W        (8),
      .TICKS_PER_SEC(10),
      .SUB_W        (4),
      .ALARM_N      (2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        tick;
      logic        wr;
      logic        rd;
      logic [2:0]  addr;
      logic [31:0] data;
      logic        chk;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[18];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic setBus(input logic t, input logic w, input logic r,
                         input logic [2:0] a, input logic [31:0] d);
      bus.tick    = t;
      bus.wr_en   = w;
      bus.rd_en   = r;
      bus.addr    = a;
      bus.wr_data = d;
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
      bus.tick  = 1'b0;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
   endtask

   task automatic applyStimulus(input logic t, input logic w, input logic r,
                                input logic [2:0] a, input logic [31:0] d);
      setBus(t, w, r, a, d);
      stepClock();
   endtask

   task automatic tickN(input int n);
      repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
   endtask

   task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
      applyStimulus(1'b0, 1'b1, 1'b0, a, d);
   endtask

   task automatic readReg(input logic [2:0] a, input logic [31:0] exp, input string name);
      setBus(1'b0, 1'b0, 1'b1, a, 32'h0);
      #1;
      checkOutput(name, bus.rd_data, exp);
      stepClock();
   endtask

   task automatic peekReg(input logic [2:0] a, input logic [31:0] exp, input string name);
      setBus(1'b0, 1'b0, 1'b0, a, 32'h0);
      #0.1;
      checkOutput(name, bus.rd_data, exp);
   endtask

   task automatic checkIrq(input logic exp, input string name);
      #0.1;
      checkOutput(name, {31'b0, bus.irq}, {31'b0, exp});
   endtask

   initial begin
      nChecks = 0;
      nFails  = 0;
      rst_n   = 1'b0;
      setBus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);

      vecs[0]  = '{1'b0, 1'b1, 1'b0, 3'd4, 32'h55,     1'b0, 32'h0,   "wr_alarm0"};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 3'd4, 32'h0,      1'b1, 32'h55,  "rd_alarm0"};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 3'd5, 32'hAA,     1'b0, 32'h0,   "wr_alarm1"};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 3'd5, 32'h0,      1'b1, 32'hAA,  "rd_alarm1"};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 3'd2, 32'hFFFF_FF01, 1'b0, 32'h0, "wr_ctrl"};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 3'd2, 32'h0,      1'b1, 32'h301, "rd_ctrl"};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 3'd6, 32'hDEAD,   1'b0, 32'h0,   "wr_addr6"};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 3'd6, 32'h0,      1'b1, 32'h0,   "rd_addr6"};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 3'd7, 32'h0,      1'b1, 32'h0,   "rd_addr7"};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 3'd1, 32'h7,      1'b0, 32'h0,   "wr_subsec"};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 3'd1, 32'h0,      1'b1, 32'h8,   "subsec_ro"};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 3'd4, 32'h11,     1'b1, 32'h55,  "rdwr_prewrite"};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 3'd4, 32'h0,      1'b1, 32'h11,  "rdwr_postwrite"};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 3'd2, 32'h1,      1'b0, 32'h0,   "wr_ctrl_run"};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 3'd2, 32'h0,      1'b1, 32'h1,   "rd_ctrl_run"};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 3'd3, 32'h0,      1'b1, 32'h0,   "rd_status"};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 3'd0, 32'h1234,   1'b0, 32'h0,   "wr_seconds"};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h0,      1'b1, 32'h34,  "rd_seconds_trunc"};

      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state
      peekReg(3'd0, 32'h0, "rst_sec");
      peekReg(3'd1, 32'h0, "rst_snap");
      peekReg(3'd2, 32'h1, "rst_ctrl");
      peekReg(3'd3, 32'h0, "rst_status");
      peekReg(3'd4, 32'h0, "rst_alarm0");
      checkIrq(1'b0, "rst_irq");

      // 25 ticks then coherent seconds/subsec read
      tickN(25);
      readReg(3'd0, 32'h2, "cnt25_sec");
      tickN(3);
      readReg(3'd1, 32'h5, "snap_held");
      readReg(3'd0, 32'h2, "cnt28_sec");
      readReg(3'd1, 32'h8, "snap_live");

      // Register access table
      for (int i = 0; i < 18; i++) begin
         setBus(vecs[i].tick, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data);
         #1;
         if (vecs[i].chk) checkOutput(vecs[i].name, bus.rd_data, vecs[i].exp);
         checkOutput({vecs[i].name, "_irq"}, {31'b0, bus.irq}, 32'h0);
         stepClock();
      end

      // Seconds wrap from all-ones
      writeReg(3'd0, 32'hFF);
      tickN(9);
      peekReg(3'd0, 32'hFF, "pre_wrap_sec");
      tickN(1);
      tickN(3);
      readReg(3'd0, 32'h0, "wrap_sec");
      readReg(3'd1, 32'h3, "wrap_sub");

      // SECONDS write on the same edge as a rollover tick
      writeReg(3'd0, 32'h7);
      tickN(9);
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 32'h40);
      readReg(3'd0, 32'h40, "wrprio_sec");
      readReg(3'd1, 32'h0, "wrprio_sub");
      tickN(10);
      readReg(3'd0, 32'h41, "wrprio_next_sec");

      // Alarm channel 0
      writeReg(3'd4, 32'h3);
      writeReg(3'd2, 32'h101);
      writeReg(3'd0, 32'h0);
      tickN(29);
      peekReg(3'd3, 32'h0, "alarm_before");
      checkIrq(1'b0, "irq_before");
      tickN(1);
      peekReg(3'd3, 32'h1, "alarm_pending");
      checkIrq(1'b1, "irq_set");
      writeReg(3'd3, 32'h0);
      peekReg(3'd3, 32'h1, "w1c_zero");
      writeReg(3'd3, 32'h1);
      peekReg(3'd3, 32'h0, "w1c_clear");
      checkIrq(1'b0, "irq_cleared");

      writeReg(3'd0, 32'h2);
      tickN(9);
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 32'h1);
      peekReg(3'd3, 32'h1, "set_beats_w1c");
      checkIrq(1'b1, "irq_set_beats_w1c");
      writeReg(3'd2, 32'h001);
      checkIrq(1'b0, "irq_masked");
      peekReg(3'd3, 32'h1, "pending_sticky");
      writeReg(3'd2, 32'h101);
      checkIrq(1'b1, "irq_unmasked");
      writeReg(3'd3, 32'h1);

      // Alarm channel 1 via SECONDS write, then compare write equal to sec
      writeReg(3'd5, 32'h20);
      writeReg(3'd2, 32'h301);
      writeReg(3'd0, 32'h20);
      peekReg(3'd3, 32'h2, "alarm1_on_write");
      checkIrq(1'b1, "irq_alarm1");
      writeReg(3'd3, 32'h3);
      writeReg(3'd4, 32'h20);
      peekReg(3'd3, 32'h0, "cmp_write_nofire");

      // run=0 freezes the counters
      writeReg(3'd2, 32'h0);
      writeReg(3'd0, 32'h10);
      tickN(50);
      readReg(3'd0, 32'h10, "frozen_sec");
      readReg(3'd1, 32'h0, "frozen_sub");
      writeReg(3'd2, 32'h1);
      tickN(10);
      readReg(3'd0, 32'h11, "resume_sec");
      readReg(3'd1, 32'h0, "resume_sub");

      // Asynchronous reset mid-count with a pending alarm
      writeReg(3'd4, 32'h12);
      writeReg(3'd2, 32'h101);
      tickN(10);
      tickN(3);
      checkIrq(1'b1, "irq_before_reset");
      #2;
      rst_n = 1'b0;
      checkIrq(1'b0, "irq_async_reset");
      peekReg(3'd0, 32'h0, "arst_sec");
      peekReg(3'd1, 32'h0, "arst_snap");
      peekReg(3'd2, 32'h1, "arst_ctrl");
      peekReg(3'd3, 32'h0, "arst_status");
      peekReg(3'd4, 32'h0, "arst_alarm0");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tickN(9);
      readReg(3'd0, 32'h0, "post_reset_sec9");
      tickN(1);
      readReg(3'd0, 32'h1, "post_reset_sec10");

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
